// File: rtl/t_ff_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : t_ff_monitor
//  Brief    : Observes a T flip-flop (its T input and Q output), recovers the
//             applied toggle from successive Q samples and flags any edge where
//             Q did not follow the previous T. Counts toggles and mismatches,
//             with a warm-up phase and an absorbing FAIL state.
//  Revision : 1.0 - initial release
// ============================================================================
module t_ff_monitor #(
  parameter int CNT_W     = 8,
  parameter int WARMUP    = 2,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             T,
  input  logic             Q,
  output logic             t_rec,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WARM  = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_ERR_LIMIT = CNT_W'(ERR_LIMIT);
  localparam logic [3:0]       c_WARM_LAST = 4'(WARMUP - 1);

  state_t           r_state;
  logic             r_q_prev;
  logic             r_t_prev;
  logic [3:0]       r_warm_cnt;
  logic             r_t_rec;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_toggle_cnt;
  logic [CNT_W-1:0] r_mismatch_cnt;

  logic             w_t_rec;
  logic             w_toggle;
  logic             w_mm;
  logic [CNT_W-1:0] w_toggle_next;
  logic [CNT_W-1:0] w_mm_cnt_next;

  assign w_t_rec  = Q ^ r_q_prev;
  assign w_toggle = (Q != r_q_prev);

  // Mismatch when the recovered toggle differs from the previous T. The
  // default-then-clear form makes an unknown comparison count as an error.
  always_comb begin
    w_mm = 1'b1;
    if (w_t_rec == r_t_prev) begin
      w_mm = 1'b0;
    end
  end

  // Saturating next values for both counters.
  always_comb begin
    w_toggle_next = (r_toggle_cnt == c_CNT_MAX) ? r_toggle_cnt : r_toggle_cnt + CNT_W'(1);
    w_mm_cnt_next = (r_mismatch_cnt == c_CNT_MAX) ? r_mismatch_cnt : r_mismatch_cnt + CNT_W'(1);
  end

  // Monitor state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_q_prev       <= 1'b0;
      r_t_prev       <= 1'b0;
      r_warm_cnt     <= 4'd0;
      r_t_rec        <= 1'b0;
      r_mismatch     <= 1'b0;
      r_err_sticky   <= 1'b0;
      r_toggle_cnt   <= '0;
      r_mismatch_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_t_rec    <= 1'b0;
          r_mismatch <= 1'b0;
          if (en) begin
            r_state    <= S_WARM;
            r_warm_cnt <= 4'd0;
            r_q_prev   <= Q;
            r_t_prev   <= T;
          end
        end

        S_WARM: begin
          r_t_rec    <= 1'b0;
          r_mismatch <= 1'b0;
          if (!en) begin
            r_state <= S_IDLE;
          end else begin
            r_q_prev   <= Q;
            r_t_prev   <= T;
            r_warm_cnt <= r_warm_cnt + 4'd1;
            if (r_warm_cnt == c_WARM_LAST) begin
              r_state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (!en) begin
            // Leaving discards the current sample; counters are kept.
            r_state    <= S_IDLE;
            r_t_rec    <= 1'b0;
            r_mismatch <= 1'b0;
          end else begin
            r_t_rec    <= w_t_rec;
            r_mismatch <= w_mm;
            r_q_prev   <= Q;
            r_t_prev   <= T;
            if (w_toggle) begin
              r_toggle_cnt <= w_toggle_next;
            end
            if (w_mm) begin
              r_mismatch_cnt <= w_mm_cnt_next;
              r_err_sticky   <= 1'b1;
              if (w_mm_cnt_next >= c_ERR_LIMIT) begin
                r_state <= S_FAIL;
              end
            end
          end
        end

        S_FAIL: begin
          // Absorbing: en ignored, counters frozen, t_rec keeps tracking.
          r_t_rec    <= w_t_rec;
          r_mismatch <= 1'b0;
          r_q_prev   <= Q;
          r_t_prev   <= T;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign t_rec        = r_t_rec;
  assign mismatch     = r_mismatch;
  assign err_sticky   = r_err_sticky;
  assign toggle_cnt   = r_toggle_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_t_ff_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_t_ff_monitor
//  Brief    : Directed-vector bench for t_ff_monitor with a scoreboard queue
//             and a separate monitor process.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_t_ff_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, T, Q;
  logic       t_rec, mismatch, err_sticky;
  logic [7:0] toggle_cnt, mismatch_cnt;
  logic [1:0] state;

  // Second instance with narrow counters for the saturation case.
  logic       en2, T2, Q2;
  logic       t_rec2, mismatch2, err_sticky2;
  logic [1:0] toggle_cnt2, mismatch_cnt2;
  logic [1:0] state2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         idx;
    logic [1:0] st;
    logic       trec;
    logic       mm;
    logic       err;
    logic [7:0] tc;
    logic [7:0] mc;
  } exp_t;

  exp_t sb[$];
  exp_t m_x;

  t_ff_monitor #(.CNT_W(8), .WARMUP(2), .ERR_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .T(T), .Q(Q),
    .t_rec(t_rec), .mismatch(mismatch), .err_sticky(err_sticky),
    .toggle_cnt(toggle_cnt), .mismatch_cnt(mismatch_cnt), .state(state)
  );

  t_ff_monitor #(.CNT_W(2), .WARMUP(2), .ERR_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .T(T2), .Q(Q2),
    .t_rec(t_rec2), .mismatch(mismatch2), .err_sticky(err_sticky2),
    .toggle_cnt(toggle_cnt2), .mismatch_cnt(mismatch_cnt2), .state(state2)
  );

  always #5 clk = ~clk;

  // Monitor: one expected snapshot per stimulated edge, compared 1 ns after it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m_x = sb.pop_front();
      n_checks++;
      if ({state, t_rec, mismatch, err_sticky, toggle_cnt, mismatch_cnt} ===
          {m_x.st, m_x.trec, m_x.mm, m_x.err, m_x.tc, m_x.mc}) begin
        n_pass++;
      end else begin
        $display("FAIL step%0d: got st=%0d trec=%b mm=%b err=%b tc=%0d mc=%0d, want st=%0d trec=%b mm=%b err=%b tc=%0d mc=%0d",
                 m_x.idx, state, t_rec, mismatch, err_sticky, toggle_cnt, mismatch_cnt,
                 m_x.st, m_x.trec, m_x.mm, m_x.err, m_x.tc, m_x.mc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Drive one vector before the next rising edge and queue what must follow it.
  task automatic step(input int idx, input logic e, input logic t, input logic q,
                      input logic [1:0] st, input logic trec, input logic mm,
                      input logic err, input int tc, input int mc);
    exp_t x;
    @(negedge clk);
    en = e; T = t; Q = q;
    x.idx = idx; x.st = st; x.trec = trec; x.mm = mm; x.err = err;
    x.tc = tc[7:0]; x.mc = mc[7:0];
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic q2g;
    rst = 1'b1; en = 1'b0; T = 1'b0; Q = 1'b0;
    en2 = 1'b0; T2 = 1'b0; Q2 = 1'b0;
    #8;
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_outs", {13'd0, t_rec, mismatch, err_sticky, toggle_cnt, mismatch_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Warm-up with golden T-FF, T=0 for 3 cycles
    //     idx en T  Q  st trec mm err tc mc
    step(1,  1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(2,  1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(3,  1, 0, 0, 2, 0, 0, 0, 0, 0);
    // T=1 for 6 cycles, Q toggles each edge after the first
    step(4,  1, 1, 0, 2, 0, 0, 0, 0, 0);
    step(5,  1, 1, 1, 2, 1, 0, 0, 1, 0);
    step(6,  1, 1, 0, 2, 1, 0, 0, 2, 0);
    step(7,  1, 1, 1, 2, 1, 0, 0, 3, 0);
    step(8,  1, 1, 0, 2, 1, 0, 0, 4, 0);
    step(9,  1, 1, 1, 2, 1, 0, 0, 5, 0);
    step(10, 1, 0, 0, 2, 1, 0, 0, 6, 0);
    step(11, 1, 0, 0, 2, 0, 0, 0, 6, 0);
    // Hold fault: Q stuck at 0 after T=1, twice
    step(12, 1, 1, 0, 2, 0, 0, 0, 6, 0);
    step(13, 1, 0, 0, 2, 0, 1, 1, 6, 1);
    step(14, 1, 1, 0, 2, 0, 0, 1, 6, 1);
    step(15, 1, 0, 0, 2, 0, 1, 1, 6, 2);
    step(16, 1, 0, 0, 2, 0, 0, 1, 6, 2);
    // Enable drop and re-entry; counters retained
    step(17, 0, 0, 0, 0, 0, 0, 1, 6, 2);
    step(18, 0, 0, 0, 0, 0, 0, 1, 6, 2);
    step(19, 1, 0, 0, 1, 0, 0, 1, 6, 2);
    step(20, 1, 0, 0, 1, 0, 0, 1, 6, 2);
    step(21, 1, 0, 0, 2, 0, 0, 1, 6, 2);
    step(22, 1, 1, 0, 2, 0, 0, 1, 6, 2);
    step(23, 1, 1, 1, 2, 1, 0, 1, 7, 2);
    step(24, 1, 0, 0, 2, 1, 0, 1, 8, 2);
    // Spurious toggles reach the error limit
    step(25, 1, 0, 1, 2, 1, 1, 1, 9, 3);
    step(26, 1, 0, 0, 3, 1, 1, 1, 10, 4);
    // FAIL absorbing: en ignored, counters frozen, t_rec tracks
    step(27, 1, 0, 1, 3, 1, 0, 1, 10, 4);
    step(28, 0, 0, 1, 3, 0, 0, 1, 10, 4);
    step(29, 0, 0, 0, 3, 1, 0, 1, 10, 4);

    // Short asynchronous reset pulse between edges
    @(negedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, state}, 32'd0);
    chk("async_rst_outs", {13'd0, t_rec, mismatch, err_sticky, toggle_cnt, mismatch_cnt}, 32'd0);

    // First edges after reset behave as normal IDLE evaluation
    step(30, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(31, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    // Saturation on 2-bit counters: golden T-FF, 6 toggles observed
    q2g = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en2 = 1'b1; T2 = 1'b0; Q2 = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      T2 = 1'b1; Q2 = q2g;
      q2g = q2g ^ 1'b1;
    end
    @(negedge clk);
    T2 = 1'b0; Q2 = q2g;
    @(negedge clk);
    chk("sat_toggle", {30'd0, toggle_cnt2}, 32'd3);
    chk("sat_state", {30'd0, state2}, 32'd2);
    chk("sat_mm_cnt", {30'd0, mismatch_cnt2}, 32'd0);
    chk("sat_err", {31'd0, err_sticky2}, 32'd0);
    T2 = 1'b1; Q2 = q2g;
    @(negedge clk);
    T2 = 1'b0; Q2 = ~q2g;
    @(negedge clk);
    chk("sat_hold", {30'd0, toggle_cnt2}, 32'd3);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
